// File: rtl/booth4_pkg.sv
// Shared constants and Booth digit decode for the radix-4 multiplier datapath.
package booth4_pkg;

  localparam int unsigned LD_M    = 0;
  localparam int unsigned LD_Q    = 1;
  localparam int unsigned LD_A    = 2;
  localparam int unsigned LD_CNT  = 3;
  localparam int unsigned LD_PROD = 4;

  localparam logic [2:0] A_CLR = 3'b000;
  localparam logic [2:0] A_ADD = 3'b001;
  localparam logic [2:0] A_SHR = 3'b010;

  localparam logic Q_LOAD   = 1'b0;
  localparam logic Q_SHIFT  = 1'b1;
  localparam logic CNT_INIT = 1'b0;
  localparam logic CNT_DEC  = 1'b1;

  // Booth digit codes {Q[1],Q[0],qm1}
  localparam logic [2:0] DIG_Z0  = 3'b000;
  localparam logic [2:0] DIG_P1A = 3'b001;
  localparam logic [2:0] DIG_P1B = 3'b010;
  localparam logic [2:0] DIG_P2  = 3'b011;
  localparam logic [2:0] DIG_M2  = 3'b100;
  localparam logic [2:0] DIG_M1A = 3'b101;
  localparam logic [2:0] DIG_M1B = 3'b110;
  localparam logic [2:0] DIG_Z1  = 3'b111;

  typedef enum logic [2:0] {
    PP_ZERO = 3'd0,
    PP_POS1 = 3'd1,
    PP_POS2 = 3'd2,
    PP_NEG1 = 3'd3,
    PP_NEG2 = 3'd4
  } pp_sel_e;

  function automatic pp_sel_e booth_decode(input logic [2:0] digit);
    case (digit)
      DIG_P1A, DIG_P1B: return PP_POS1;
      DIG_P2:           return PP_POS2;
      DIG_M2:           return PP_NEG2;
      DIG_M1A, DIG_M1B: return PP_NEG1;
      default:          return PP_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth4_pp_gen.sv
// Radix-4 Booth partial-product generator: digit and multiplicand to a
// sign-extended WIDTH+2 bit addend.
module booth4_pp_gen
  import booth4_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       digit,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH+1:0] pp_c
);

  localparam int unsigned AW = WIDTH + 2;

  logic [AW-1:0] m1_ext;
  logic [AW-1:0] m2_ext;

  assign m1_ext = {{2{m[WIDTH-1]}}, m};
  assign m2_ext = {m[WIDTH-1], m, 1'b0};

  always_comb begin
    pp_c = '0;
    case (booth_decode(digit))
      PP_POS1: pp_c = m1_ext;
      PP_POS2: pp_c = m2_ext;
      PP_NEG1: pp_c = AW'(~m1_ext + AW'(1));
      PP_NEG2: pp_c = AW'(~m2_ext + AW'(1));
      default: pp_c = '0;
    endcase
  end

endmodule

// File: rtl/booth4_datapath.sv
// Radix-4 Booth signed multiplier datapath: executes controller load/select
// strobes on M, A, Q/qm1, iteration counter and product registers.
module booth4_datapath
  import booth4_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [4:0]         ld,
  input  logic [4:0]         sel,
  output logic               flag,
  output logic [2:0]         digit,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned ITER = WIDTH / 2;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned AW   = WIDTH + 2;

  logic [WIDTH-1:0] m;
  logic [AW-1:0]    a;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic [CW-1:0]    count;
  logic [AW-1:0]    pp_c;

  booth4_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .digit (digit),
    .m     (m),
    .pp_c  (pp_c)
  );

  assign digit = {q[1:0], qm1};
  assign flag  = (count == '0);

  // Every register samples pre-edge values, so a combined shift step moves
  // the old A[1:0] into Q while A shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      m       <= '0;
      a       <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else begin
      if (ld[LD_M]) m <= data_in;

      if (ld[LD_A]) begin
        case (sel[2:0])
          A_CLR:   a <= '0;
          A_ADD:   a <= a + pp_c;
          A_SHR:   a <= {a[AW-1], a[AW-1], a[AW-1:2]};
          default: a <= a;
        endcase
      end

      if (ld[LD_Q]) begin
        if (sel[3] == Q_LOAD) begin
          q   <= data_in;
          qm1 <= 1'b0;
        end else begin
          q   <= {a[1:0], q[WIDTH-1:2]};
          qm1 <= q[1];
        end
      end

      if (ld[LD_CNT]) begin
        if (sel[4] == CNT_INIT) begin
          count <= CW'(ITER);
        end else if (count != '0) begin
          count <= count - CW'(1);
        end
      end

      if (ld[LD_PROD]) product <= {a[WIDTH-1:0], q};
    end
  end

endmodule

// File: tb/tb_booth4_datapath.sv
// Self-checking bench for booth4_datapath: directed corner cases plus random
// signed operand pairs against a plain integer multiply.
module tb_booth4_datapath;

  localparam int unsigned W    = 8;
  localparam int unsigned ITER = W / 2;
  localparam int unsigned PW   = 2 * W;

  localparam logic [4:0] LDV_M    = 5'b00001;
  localparam logic [4:0] LDV_PROD = 5'b10000;
  localparam logic [4:0] LDV_A    = 5'b00100;
  localparam logic [4:0] LDV_CNT  = 5'b01000;
  localparam logic [4:0] LDV_INIT = 5'b01110;  // Q load + A clear + count init
  localparam logic [4:0] SEL_ADD  = 5'b00001;
  localparam logic [4:0] SEL_SHFT = 5'b11010;  // dec, Q shift, A shr
  localparam logic [4:0] SEL_DEC  = 5'b10000;

  logic          clk;
  logic          rst;
  logic [W-1:0]  data_in;
  logic [4:0]    ld;
  logic [4:0]    sel;
  logic          flag;
  logic [2:0]    digit;
  logic [PW-1:0] product;

  int total = 0;
  int bad   = 0;

  booth4_datapath #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .ld      (ld),
    .sel     (sel),
    .flag    (flag),
    .digit   (digit),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
    int p;
    p = int'(x) * int'(y);
    return PW'(p);
  endfunction

  // One clock: drive on falling edge, outputs settle 1 time unit after rising edge.
  task automatic step(input logic [4:0] l, input logic [4:0] s, input logic [W-1:0] d);
    @(negedge clk);
    ld      = l;
    sel     = s;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(5'b0, 5'($urandom), W'($urandom));
  endtask

  task automatic load_ops(input logic [W-1:0] x, input logic [W-1:0] y);
    step(LDV_M, 5'($urandom), x);
    step(LDV_INIT, 5'b00000, y);
  endtask

  task automatic run_mult(input logic [W-1:0] x, input logic [W-1:0] y, input bit chk_flag);
    load_ops(x, y);
    if (chk_flag) begin
      check("digit_after_load", 64'(digit), 64'({y[1:0], 1'b0}));
      check("flag_after_init", 64'(flag), 64'(0));
    end
    for (int i = 0; i < int'(ITER); i++) begin
      step(LDV_A, SEL_ADD, W'($urandom));
      step(LDV_INIT, SEL_SHFT, W'($urandom));
      if (chk_flag) check($sformatf("flag_iter%0d", i), 64'(flag), 64'(i == int'(ITER) - 1));
    end
    step(LDV_PROD, 5'($urandom), W'($urandom));
    check($sformatf("prod_%0d_x_%0d", $signed(x), $signed(y)), 64'(product), 64'(ref_mul(x, y)));
  endtask

  initial begin
    rst = 1'b1;
    ld = 5'b0; sel = 5'b0; data_in = '0;
    // Reset with arbitrary strobes: reset must win
    for (int i = 0; i < 2; i++) step(5'($urandom), 5'($urandom), W'($urandom));
    check("rst_product", 64'(product), 64'(0));
    check("rst_flag", 64'(flag), 64'(1));
    check("rst_digit", 64'(digit), 64'(0));
    rst = 1'b0;

    // Directed products from the operand table
    run_mult(8'd6, 8'd5, 1'b1);
    check("prod_6x5_const", 64'(product), 64'(16'h001E));
    run_mult(8'd7, 8'hFD, 1'b1);
    check("prod_7xm3_const", 64'(product), 64'(16'hFFEB));
    run_mult(8'h80, 8'h80, 1'b1);
    check("prod_m128xm128_const", 64'(product), 64'(16'h4000));
    run_mult(8'h80, 8'h7F, 1'b1);
    check("prod_m128x127_const", 64'(product), 64'(16'hC080));
    idle();
    check("prod_holds", 64'(product), 64'(16'hC080));

    // Counter saturates at zero after more decrements than iterations
    step(LDV_CNT, 5'b00000, W'($urandom));
    for (int i = 1; i <= 6; i++) begin
      step(LDV_CNT, SEL_DEC, W'($urandom));
      check($sformatf("cnt_dec%0d_flag", i), 64'(flag), 64'(i >= int'(ITER)));
    end

    // Product capture together with a shift step sees pre-shift {A,Q}
    load_ops(8'd6, 8'd5);
    step(LDV_A, SEL_ADD, W'($urandom));
    step(LDV_INIT | LDV_PROD, SEL_SHFT, W'($urandom));
    check("prod_with_shift", 64'(product), 64'(16'h0605));

    // Unused A select codes leave A alone
    for (int c = 3; c < 8; c++) begin
      load_ops(8'd6, 8'd5);
      step(LDV_A, SEL_ADD, W'($urandom));
      step(LDV_A, 5'(c), W'($urandom));
      step(LDV_PROD, 5'b0, W'($urandom));
      check($sformatf("a_hold_code%0d", c), 64'(product), 64'(16'h0605));
    end

    // Registers hold while their ld bit is low
    step(5'b0, SEL_SHFT, W'($urandom));
    step(LDV_PROD, 5'b0, W'($urandom));
    check("hold_no_ld", 64'(product), 64'(16'h0605));

    // Reset mid-operation, then a full run
    run_mult(8'd7, 8'hFD, 1'b0);
    load_ops(8'd9, 8'd11);
    for (int i = 0; i < 2; i++) begin
      step(LDV_A, SEL_ADD, W'($urandom));
      step(LDV_INIT, SEL_SHFT, W'($urandom));
    end
    rst = 1'b1;
    step(5'($urandom), 5'($urandom), W'($urandom));
    rst = 1'b0;
    check("midrst_product", 64'(product), 64'(0));
    check("midrst_flag", 64'(flag), 64'(1));
    check("midrst_digit", 64'(digit), 64'(0));
    step(LDV_PROD, 5'b0, W'($urandom));
    check("midrst_aq_clear", 64'(product), 64'(0));
    // M was cleared: adding +M with digit 010 keeps A at zero
    step(LDV_INIT, 5'b00000, 8'd1);
    step(LDV_A, SEL_ADD, W'($urandom));
    step(LDV_PROD, 5'b0, W'($urandom));
    check("midrst_m_clear", 64'(product), 64'(16'h0001));
    run_mult(8'd9, 8'd11, 1'b1);

    // Random signed operand pairs
    for (int n = 0; n < 1000; n++) begin
      run_mult(W'($urandom), W'($urandom), (n % 50) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
